// File: rtl/nes_rom_dumper_pkg.sv
// Shared types and constants for the iNES ROM dump path.
package nes_dump_pkg;

    localparam int unsigned ADDR_W         = 22;
    localparam int unsigned HDR_LEN        = 16;
    localparam int unsigned PRG_PAGE_SHIFT = 14;
    localparam int unsigned CHR_PAGE_SHIFT = 13;
    localparam int unsigned MAX_PRG_PAGES  = 128;
    localparam int unsigned MAX_CHR_PAGES  = 64;

    // "NES\x1A", element 0 is the first byte on the wire
    localparam logic [3:0][7:0] INES_MAGIC = {8'h1A, 8'h53, 8'h45, 8'h4E};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE,
        S_ERROR
    } dump_state_t;

    typedef enum logic {
        SEC_PRG,
        SEC_CHR
    } dump_section_t;

    typedef struct packed {
        logic [7:0] prg_pages;
        logic [7:0] chr_pages;
        logic [7:0] mapper;
        logic       mirroring;
        logic       has_saves;
        logic       four_screen;
    } ines_attr_t;

    // Sizes the dumper refuses to stream
    function automatic logic attr_invalid(input ines_attr_t a);
        return (a.prg_pages == 8'd0) ||
               (a.prg_pages > 8'(MAX_PRG_PAGES)) ||
               (a.chr_pages > 8'(MAX_CHR_PAGES));
    endfunction

endpackage

// File: rtl/nes_rom_dumper_if.sv
// SDRAM read port plus upload byte stream seen by the ROM dumper.
interface nes_rom_dumper_if;
    import nes_dump_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr, mem_rd, out_data, out_valid,
        input  mem_ack, mem_data, out_ready
    );

    modport slave (
        input  mem_addr, mem_rd, out_data, out_valid,
        output mem_ack, mem_data, out_ready
    );

endinterface

// File: rtl/nes_rom_dumper_header.sv
// Combinational iNES 1.0 header byte selected by index from latched attributes.
module ines_header_gen
    import nes_dump_pkg::*;
(
    input  ines_attr_t i_attr,
    input  logic [3:0] i_idx,
    output logic [7:0] o_byte_c
);

    always_comb begin
        o_byte_c = 8'h00;
        case (i_idx)
            4'd0, 4'd1, 4'd2, 4'd3: o_byte_c = INES_MAGIC[i_idx[1:0]];
            4'd4: o_byte_c = i_attr.prg_pages;
            4'd5: o_byte_c = i_attr.chr_pages;
            4'd6: o_byte_c = {i_attr.mapper[3:0], i_attr.four_screen, 1'b0,
                              i_attr.has_saves, i_attr.mirroring};
            4'd7: o_byte_c = {i_attr.mapper[7:4], 4'h0};
            default: o_byte_c = 8'h00;
        endcase
    end

endmodule

// File: rtl/nes_rom_dumper.sv
// Streams header, PRG and CHR out of SDRAM as an iNES image, one byte in flight.
module nes_rom_dumper
    import nes_dump_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PRG_BASE    = 22'h000000,
    parameter logic [ADDR_W-1:0] CHR_BASE    = 22'h200000,
    parameter int unsigned       ACK_TIMEOUT = 255,
    parameter int unsigned       PRG_SHIFT   = PRG_PAGE_SHIFT,
    parameter int unsigned       CHR_SHIFT   = CHR_PAGE_SHIFT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [7:0]              i_prg_pages,
    input  logic [7:0]              i_chr_pages,
    input  logic [7:0]              i_mapper,
    input  logic                    i_mirroring,
    input  logic                    i_has_saves,
    input  logic                    i_four_screen,
    nes_rom_dumper_if.master        bus,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error
);

    dump_state_t       r_state;
    dump_section_t     r_section;
    ines_attr_t        r_attr;
    logic [3:0]        r_hdr_idx;
    logic [ADDR_W-1:0] r_bytes_left;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_to_cnt;
    logic [7:0]        r_out_data;
    logic              r_mem_rd;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    ines_attr_t        w_new_attr;
    logic [7:0]        w_hdr_byte;
    logic              w_xfer;

    assign w_new_attr = '{prg_pages:   i_prg_pages,
                          chr_pages:   i_chr_pages,
                          mapper:      i_mapper,
                          mirroring:   i_mirroring,
                          has_saves:   i_has_saves,
                          four_screen: i_four_screen};

    assign w_xfer = r_out_valid && bus.out_ready;

    ines_header_gen u_hdr (
        .i_attr   (r_attr),
        .i_idx    (r_hdr_idx),
        .o_byte_c (w_hdr_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_section    <= SEC_PRG;
            r_attr       <= '0;
            r_hdr_idx    <= 4'd0;
            r_bytes_left <= '0;
            r_mem_addr   <= '0;
            r_to_cnt     <= 8'd0;
            r_out_data   <= 8'h00;
            r_mem_rd     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_attr    <= w_new_attr;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_hdr_idx <= 4'd0;
                        r_state   <= attr_invalid(w_new_attr) ? S_ERROR : S_HEADER;
                    end
                end
                // Two cycles per header byte: load the output register, then hand it off
                S_HEADER: begin
                    if (!r_out_valid) begin
                        r_out_data  <= w_hdr_byte;
                        r_out_valid <= 1'b1;
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_hdr_idx   <= r_hdr_idx + 4'd1;
                        if (r_hdr_idx == 4'(HDR_LEN - 1)) begin
                            r_section    <= SEC_PRG;
                            r_mem_addr   <= PRG_BASE;
                            r_bytes_left <= ADDR_W'(r_attr.prg_pages) << PRG_SHIFT;
                            r_state      <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    r_mem_rd <= 1'b1;
                    r_to_cnt <= 8'd0;
                    r_state  <= S_WAIT;
                end
                // An ack on the final counted cycle still wins over the timeout
                S_WAIT: begin
                    r_to_cnt <= r_to_cnt + 8'd1;
                    if (bus.mem_ack) begin
                        r_out_data  <= bus.mem_data;
                        r_out_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end else if (r_to_cnt == 8'(ACK_TIMEOUT - 1)) begin
                        r_state <= S_ERROR;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_out_valid  <= 1'b0;
                        r_mem_addr   <= r_mem_addr + ADDR_W'(1);
                        r_bytes_left <= r_bytes_left - ADDR_W'(1);
                        if (r_bytes_left != ADDR_W'(1)) begin
                            r_state <= S_READ;
                        end else if (r_section == SEC_PRG && r_attr.chr_pages != 8'd0) begin
                            r_section    <= SEC_CHR;
                            r_mem_addr   <= CHR_BASE;
                            r_bytes_left <= ADDR_W'(r_attr.chr_pages) << CHR_SHIFT;
                            r_state      <= S_READ;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    r_error     <= 1'b1;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;

endmodule

// File: tb/tb_nes_rom_dumper.sv
// Directed bench for nes_rom_dumper: SDRAM responder model plus byte scoreboard.
module tb_nes_rom_dumper;
    import nes_dump_pkg::*;

    localparam int unsigned TB_PRG_SHIFT = 7;
    localparam int unsigned TB_CHR_SHIFT = 6;
    localparam int unsigned TB_TIMEOUT   = 255;
    localparam logic [21:0] PRG_B        = 22'h000000;
    localparam logic [21:0] CHR_B        = 22'h200000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] prg, chr, mapper;
    logic       mirr, saves, four;
    logic       busy, done, error;

    nes_rom_dumper_if bus();

    nes_rom_dumper #(
        .PRG_BASE    (PRG_B),
        .CHR_BASE    (CHR_B),
        .ACK_TIMEOUT (TB_TIMEOUT),
        .PRG_SHIFT   (TB_PRG_SHIFT),
        .CHR_SHIFT   (TB_CHR_SHIFT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (start),
        .i_prg_pages   (prg),
        .i_chr_pages   (chr),
        .i_mapper      (mapper),
        .i_mirroring   (mirr),
        .i_has_saves   (saves),
        .i_four_screen (four),
        .bus           (bus),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  exp_bytes[$];
    logic [21:0] exp_addrs[$];

    int          lat         = 2;
    int          rd_num      = 0;
    int          withhold_at = -1;
    int unsigned wh_cyc      = 0;
    bit          rand_ready  = 1'b0;
    int          valid_cnt   = 0;

    function automatic logic [7:0] mem_byte(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SDRAM model: one outstanding read, ack 'lat' cycles after mem_rd is seen
    initial begin
        int         pend;
        logic [7:0] pend_data;
        logic [21:0] ea;
        pend         = 0;
        pend_data    = 8'h00;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (bus.mem_rd === 1'b1) begin
                rd_num++;
                ea = (exp_addrs.size() > 0) ? exp_addrs.pop_front() : 22'h3FFFFF;
                check("mem_addr", 32'(bus.mem_addr), 32'(ea));
                if (rd_num == withhold_at) begin
                    wh_cyc = cyc;
                end else begin
                    pend      = lat + 1;
                    pend_data = mem_byte(bus.mem_addr);
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = pend_data;
                end
            end
        end
    end

    // Stream sink: drives out_ready, checks hold-while-stalled and byte order
    initial begin
        logic       pv, pr;
        logic [7:0] pd;
        logic [31:0] ev;
        pv = 1'b0;
        pr = 1'b1;
        pd = 8'h00;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (bus.out_valid) valid_cnt++;
                if (pv && !pr) begin
                    check("hold_valid", 32'(bus.out_valid), 32'd1);
                    check("hold_data", 32'(bus.out_data), 32'(pd));
                end
                pr = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
                bus.out_ready = pr;
                if (bus.out_valid && pr) begin
                    ev = (exp_bytes.size() > 0) ? 32'(exp_bytes.pop_front()) : 32'h100;
                    check("out_byte", 32'(bus.out_data), ev);
                end
                pv = bus.out_valid;
                pd = bus.out_data;
            end
        end
    end

    task automatic push_dump(input logic [7:0] p, c, m, input logic mi, s, f);
        logic [7:0]  h[16];
        logic [21:0] a;
        int          np, nc;
        for (int i = 0; i < 16; i++) h[i] = 8'h00;
        h[0] = 8'h4E; h[1] = 8'h45; h[2] = 8'h53; h[3] = 8'h1A;
        h[4] = p;
        h[5] = c;
        h[6] = 8'((int'(m) % 16) * 16 + int'(f) * 8 + int'(s) * 2 + int'(mi));
        h[7] = 8'((int'(m) / 16) * 16);
        for (int i = 0; i < 16; i++) exp_bytes.push_back(h[i]);
        np = int'(p) << TB_PRG_SHIFT;
        nc = int'(c) << TB_CHR_SHIFT;
        for (int i = 0; i < np; i++) begin
            a = PRG_B + 22'(i);
            exp_addrs.push_back(a);
            exp_bytes.push_back(mem_byte(a));
        end
        for (int i = 0; i < nc; i++) begin
            a = CHR_B + 22'(i);
            exp_addrs.push_back(a);
            exp_bytes.push_back(mem_byte(a));
        end
    endtask

    task automatic pulse_start(input logic [7:0] p, c, m, input logic mi, s, f);
        @(negedge clk);
        prg = p; chr = c; mapper = m; mirr = mi; saves = s; four = f;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int elapsed);
        int n;
        n = 0;
        while (!(done && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_time"}, 32'(n < budget), 32'd1);
        elapsed = n;
    endtask

    task automatic run_dump(input string tag, input logic [7:0] p, c, m, input logic mi, s, f,
                            output int elapsed);
        push_dump(p, c, m, mi, s, f);
        pulse_start(p, c, m, mi, s, f);
        wait_done(tag, 20000, elapsed);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
        check({tag, "_reads_left"}, 32'(exp_addrs.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
        $fatal(1);
    end

    initial begin
        int elapsed, rd0, v0, n;
        logic [7:0] bad_prg[4];
        logic [7:0] bad_chr[4];

        reset = 1'b1; start = 1'b1;
        prg = 8'd1; chr = 8'd1; mapper = 8'd0; mirr = 1'b0; saves = 1'b0; four = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_rd", 32'(bus.mem_rd), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic dump, latency 2, plus a start while busy that must be ignored
        lat = 2;
        push_dump(8'd1, 8'd1, 8'd4, 1'b1, 1'b0, 1'b0);
        pulse_start(8'd1, 8'd1, 8'd4, 1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        prg = 8'd3; chr = 8'd0; mapper = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("dump1", 20000, elapsed);
        check("dump1_error", 32'(error), 32'd0);
        check("dump1_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("dump1_reads_left", 32'(exp_addrs.size()), 32'd0);

        // No CHR, full attribute bits, zero-latency ack: 3 cycles per data byte
        lat = 0;
        run_dump("dump2", 8'd2, 8'd0, 8'h1F, 1'b0, 1'b1, 1'b1, elapsed);
        check("dump2_throughput", 32'(elapsed <= 16 * 2 + (2 << TB_PRG_SHIFT) * 3 + 4), 32'd1);

        // Same image as dump1 under a stalling sink
        lat = 2;
        rand_ready = 1'b1;
        run_dump("dump3", 8'd1, 8'd1, 8'd4, 1'b1, 1'b0, 1'b0, elapsed);
        rand_ready = 1'b0;

        // Rejected sizes: error within two cycles, no reads, no stream bytes
        bad_prg[0] = 8'd0;   bad_chr[0] = 8'd1;
        bad_prg[1] = 8'd200; bad_chr[1] = 8'd1;
        bad_prg[2] = 8'd129; bad_chr[2] = 8'd0;
        bad_prg[3] = 8'd1;   bad_chr[3] = 8'd65;
        for (int k = 0; k < 4; k++) begin
            rd0 = rd_num;
            v0  = valid_cnt;
            pulse_start(bad_prg[k], bad_chr[k], 8'd0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check("bad_error", 32'(error), 32'd1);
            check("bad_done", 32'(done), 32'd1);
            check("bad_busy", 32'(busy), 32'd0);
            repeat (2) @(negedge clk);
            check("bad_no_rd", 32'(rd_num), 32'(rd0));
            check("bad_no_valid", 32'(valid_cnt), 32'(v0));
        end

        // Withhold the 5th PRG ack and expect a timeout
        lat = 2;
        push_dump(8'd1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        withhold_at = rd_num + 5;
        pulse_start(8'd1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!error && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("to_seen", 32'(error), 32'd1);
        check("to_latency_lo", 32'((cyc - wh_cyc) >= TB_TIMEOUT), 32'd1);
        check("to_latency_hi", 32'((cyc - wh_cyc) <= TB_TIMEOUT + 2), 32'd1);
        check("to_done", 32'(done), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("to_valid", 32'(bus.out_valid), 32'd0);
        withhold_at = -1;
        exp_bytes.delete();
        exp_addrs.delete();
        run_dump("after_to", 8'd1, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, elapsed);

        // Reset inside CHR with a read outstanding; its ack lands after reset
        lat = 6;
        push_dump(8'd1, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0);
        pulse_start(8'd1, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!(bus.mem_rd === 1'b1 && bus.mem_addr >= CHR_B + 22'd3) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("chr_reached", 32'(n < 5000), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_error", 32'(error), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_rd", 32'(bus.mem_rd), 32'd0);
        check("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_data", 32'(bus.out_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_bytes.delete();
        exp_addrs.delete();
        v0 = valid_cnt;
        repeat (10) @(negedge clk);
        check("stale_ack_valid", 32'(valid_cnt), 32'(v0));
        check("stale_ack_busy", 32'(busy), 32'd0);
        check("stale_ack_done", 32'(done), 32'd0);
        lat = 1;
        run_dump("after_rst", 8'd2, 8'd1, 8'h23, 1'b1, 1'b1, 1'b0, elapsed);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/nes_rom_dumper.md
Name: nes_rom_dumper

Overview:
Streams a loaded cartridge back out of SDRAM as a well-formed iNES 1.0 image: a 16-byte header rebuilt from latched cartridge attributes, then PRG from PRG_BASE, then CHR from CHR_BASE. It sits between the SDRAM arbiter read port and the IO-controller upload channel. It is the reverse path of the cartridge download/header-parse logic and is used for ROM dumps.

Parameters:
PRG_BASE, 22'h000000, SDRAM byte address of PRG page 0
CHR_BASE, 22'h200000, SDRAM byte address of CHR page 0
ACK_TIMEOUT, 255, max cycles from mem_rd to mem_ack before error (8-bit counter)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begin dump (ignored while busy)
prg_pages  in  8  16 KB PRG pages; latched on accepted start
chr_pages  in  8  8 KB CHR pages, 0 = CHR RAM; latched on start
mapper  in  8  iNES mapper number; latched on start
mirroring  in  1  header byte6 bit0; latched
has_saves  in  1  header byte6 bit1; latched
four_screen  in  1  header byte6 bit3; latched
mem_addr  out  22  SDRAM byte address
mem_rd  out  1  one-cycle read request
mem_ack  in  1  one-cycle; mem_data valid this cycle
mem_data  in  8  read data
out_data  out  8  stream byte
out_valid  out  1  stream byte valid
out_ready  in  1  sink accepts
busy  out  1  dump in progress
done  out  1  dump finished (sticky)
error  out  1  dump aborted (sticky)

Behaviour:
- Reset: state S_IDLE; mem_addr=0, mem_rd=0, out_valid=0, out_data=0, busy=0, done=0, error=0. Reset wins over start in the same cycle. Reset mid-dump aborts and discards any in-flight ack.
- Stream handshake: transfer occurs when out_valid && out_ready. While out_valid=1 and out_ready=0, out_data is held stable. out_valid does not drop until the transfer. One output register only, no prefetch.
- Accepted start (S_IDLE): latch inputs; clear done/error; busy=1.
  - prg_pages==0, prg_pages>128, or chr_pages>64: go to S_ERROR next cycle with no mem_rd.
  - Otherwise go to S_HEADER with hdr_idx=0.
- Header bytes 0..15: 4E 45 53 1A, prg_pages, chr_pages, {mapper[3:0],four_screen,1'b0,has_saves,mirroring}, {mapper[7:4],4'h0}, then 8 bytes of 00.
- S_HEADER: present byte hdr_idx. On transfer, hdr_idx++. After byte 15 transfers: section=PRG, mem_addr=PRG_BASE, bytes_left={prg_pages,14'b0} (22 bits), go to S_READ.
- S_READ: mem_rd=1 for exactly one cycle; clear the timeout counter; go to S_WAIT.
- S_WAIT: the counter increments each cycle.
  - On mem_ack: out_data=mem_data, out_valid=1, go to S_SEND.
  - If the counter reaches ACK_TIMEOUT without ack: go to S_ERROR.
  - Ack in the same cycle as timeout counts as success.
- S_SEND: on transfer, out_valid=0, mem_addr++, bytes_left--.
  - If the new bytes_left != 0: go to S_READ.
  - Else if section==PRG and chr_pages!=0: section=CHR, mem_addr=CHR_BASE, bytes_left={chr_pages,13'b0}, go to S_READ.
  - Else go to S_DONE.
- S_DONE: done=1, busy=0, return to S_IDLE. done stays high until the next accepted start.
- S_ERROR: error=1, done=1, busy=0, out_valid=0, return to S_IDLE.
- start while busy: ignored, with no effect on latched values.
- Address arithmetic wraps modulo 2^22. The size limits keep PRG below 0x200000 and CHR below 0x280000.
- Minimum throughput: one byte per 3 cycles with zero-latency ack and out_ready=1.

Decomposition:
- Package nes_dump_pkg holds:
  - enum dump_state_t {S_IDLE,S_HEADER,S_READ,S_WAIT,S_SEND,S_DONE,S_ERROR};
  - section enum {SEC_PRG,SEC_CHR};
  - constants INES_MAGIC (4×8), PRG_PAGE_SHIFT=14, CHR_PAGE_SHIFT=13, MAX_PRG_PAGES=128, MAX_CHR_PAGES=64.
- Sub-module ines_header_gen: combinational byte mux from latched attributes and a 4-bit index to a header byte.

Test Plan:
- prg=1, chr=1, mapper=4, mirroring=1, others 0, ack latency 2, out_ready=1 -> 24592 bytes. Header 4E 45 53 1A 01 01 41 00 00×8. Then mem_addr 0x000000..0x003FFF, then 0x200000..0x201FFF. done=1, error=0.
- prg=2, chr=0, mapper=0x1F, has_saves=1, four_screen=1 -> header byte6=FA, byte7=10. 16+32768 bytes, no CHR-region reads.
- Random out_ready (about 30% duty) -> out_data stable whenever out_valid && !out_ready. Byte sequence identical to the out_ready=1 run.
- prg=0, then prg=200 with chr=1 -> error=1, done=1 within 2 cycles. mem_rd never asserted, out_valid never asserted.
- Withhold mem_ack on the 5th PRG byte -> error asserted ACK_TIMEOUT cycles after that mem_rd. busy=0 afterwards, and a later start dumps correctly.
- Reset during the CHR section, then start with new sizes -> outputs return to reset values the cycle after reset. A stale ack arriving after reset is ignored. The second dump starts from header byte 0 with the new sizes.
